// File: rtl/alu_seq_pkg.sv
// Shared types, opcode constants and IR field layout for the ALU op sequencer.
package alu_seq_pkg;

  // Opcode field width and IR field positions (LSB of each field).
  localparam int unsigned OPC_BITS = 5;
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned RA_LSB   = 23;
  localparam int unsigned RB_LSB   = 19;
  localparam int unsigned RC_LSB   = 15;

  typedef logic [OPC_BITS-1:0] opc_t;

  localparam opc_t OPC_ADD = 5'b00011;
  localparam opc_t OPC_SUB = 5'b00100;
  localparam opc_t OPC_AND = 5'b00101;
  localparam opc_t OPC_OR  = 5'b00110;
  localparam opc_t OPC_MUL = 5'b01111;
  localparam opc_t OPC_DIV = 5'b10000;
  localparam opc_t OPC_NEG = 5'b10001;
  localparam opc_t OPC_NOT = 5'b10010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE,
    S_FAIL
  } state_t;

  // Single-bit control strobes, registered together.
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic pc_out;
    logic mdr_out;
    logic zlo_out;
    logic zhi_out;
    logic mar_rd;
    logic pc_rd;
    logic mdr_rd;
    logic ir_rd;
    logic y_rd;
    logic z_rd;
    logic hi_rd;
    logic lo_rd;
    logic inc_pc;
    logic read;
  } strobe_t;

  // Single-operand ops skip the Y load and take their operand from Rb.
  function automatic logic is_unary(input opc_t opc);
    return (opc == OPC_NEG) || (opc == OPC_NOT);
  endfunction

  // Ops that write back through HI/LO instead of Ra.
  function automatic logic is_muldiv(input opc_t opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

  function automatic logic is_legal(input opc_t opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_MUL, OPC_DIV, OPC_NEG, OPC_NOT: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot select; indices outside 0..N-1 give an all-zero vector.
module onehot_dec #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned N     = 16
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot_c
);

  // Compare against every position; out-of-range indices match nothing.
  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(idx) == 32'(i)) begin
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for register-register ALU instructions on the shared bus datapath.
// Outputs are registered copies of the decode of the next state, so every strobe
// lines up with its state and there is no input-to-output combinational path.
module alu_op_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned REG_IDX_W   = 4,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              PC_out,
  output logic              MDR_out,
  output logic              Zlo_out,
  output logic              Zhi_out,
  output logic              MAR_rd,
  output logic              PC_rd,
  output logic              MDR_rd,
  output logic              IR_rd,
  output logic              Y_rd,
  output logic              Z_rd,
  output logic              HI_rd,
  output logic              LO_rd,
  output logic              IncPC,
  output logic              Read,
  output logic [NREGS-1:0]  R_rd,
  output logic [NREGS-1:0]  R_wrt,
  output logic [OPC_W-1:0]  op_sel
);

  import alu_seq_pkg::*;

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  strobe_t            strb_q, strb_d;
  logic [NREGS-1:0]   r_rd_q, r_rd_d;
  logic [NREGS-1:0]   r_wrt_q, r_wrt_d;
  logic [OPC_W-1:0]   op_sel_q, op_sel_d;

  // IR field decode.
  logic [OPC_W-1:0]     opc_raw;
  opc_t                 opc;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic                 unused_ir_bits;

  assign opc_raw        = ir[OPC_LSB +: OPC_W];
  assign opc            = opc_t'(opc_raw);
  assign ra             = ir[RA_LSB +: REG_IDX_W];
  assign rb             = ir[RB_LSB +: REG_IDX_W];
  assign rc             = ir[RC_LSB +: REG_IDX_W];
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  // Register selects. The drive index depends only on the current state:
  // leaving T3 means entering a binary T4 (Rc); leaving T2 means T3 or unary T4 (Rb).
  logic [REG_IDX_W-1:0] wrt_idx_c;
  logic [NREGS-1:0]     wrt_sel_c;
  logic [NREGS-1:0]     rd_sel_c;

  assign wrt_idx_c = (state_q == S_T3) ? rc : rb;

  onehot_dec #(
    .IDX_W (REG_IDX_W),
    .N     (NREGS)
  ) u_wrt_dec (
    .idx      (wrt_idx_c),
    .onehot_c (wrt_sel_c)
  );

  onehot_dec #(
    .IDX_W (REG_IDX_W),
    .N     (NREGS)
  ) u_rd_dec (
    .idx      (ra),
    .onehot_c (rd_sel_c)
  );

  // Next state, T1 wait counter, and the strobes belonging to the next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    strb_d     = '0;
    r_rd_d     = '0;
    r_wrt_d    = '0;
    op_sel_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        state_d    = S_T1;
        wait_cnt_d = '0;
      end
      S_T1: begin
        if (mem_rdy) begin
          state_d = S_T2;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d = S_FAIL;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_T2: begin
        if (!is_legal(opc))     state_d = S_FAIL;
        else if (is_unary(opc)) state_d = S_T4;
        else                    state_d = S_T3;
      end
      S_T3:   state_d = S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_muldiv(opc) ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    strb_d.busy = (state_d != S_IDLE);

    case (state_d)
      S_T0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_rd = 1'b1;
        strb_d.inc_pc = 1'b1;
        strb_d.z_rd   = 1'b1;
      end
      S_T1: begin
        strb_d.zlo_out = 1'b1;
        strb_d.pc_rd   = 1'b1;
        strb_d.read    = 1'b1;
        strb_d.mdr_rd  = 1'b1;
      end
      S_T2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_rd   = 1'b1;
      end
      S_T3: begin
        r_wrt_d     = wrt_sel_c;
        strb_d.y_rd = 1'b1;
      end
      S_T4: begin
        r_wrt_d     = wrt_sel_c;
        op_sel_d    = opc_raw;
        strb_d.z_rd = 1'b1;
      end
      S_T5: begin
        strb_d.zlo_out = 1'b1;
        if (is_muldiv(opc)) strb_d.lo_rd = 1'b1;
        else                r_rd_d       = rd_sel_c;
      end
      S_T6: begin
        strb_d.zhi_out = 1'b1;
        strb_d.hi_rd   = 1'b1;
      end
      S_DONE:  strb_d.done = 1'b1;
      S_FAIL:  strb_d.err  = 1'b1;
      default: ;
    endcase
  end

  // State, counter and output registers; async reset clears everything at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      strb_q     <= '0;
      r_rd_q     <= '0;
      r_wrt_q    <= '0;
      op_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      strb_q     <= strb_d;
      r_rd_q     <= r_rd_d;
      r_wrt_q    <= r_wrt_d;
      op_sel_q   <= op_sel_d;
    end
  end

  assign busy    = strb_q.busy;
  assign done    = strb_q.done;
  assign err     = strb_q.err;
  assign PC_out  = strb_q.pc_out;
  assign MDR_out = strb_q.mdr_out;
  assign Zlo_out = strb_q.zlo_out;
  assign Zhi_out = strb_q.zhi_out;
  assign MAR_rd  = strb_q.mar_rd;
  assign PC_rd   = strb_q.pc_rd;
  assign MDR_rd  = strb_q.mdr_rd;
  assign IR_rd   = strb_q.ir_rd;
  assign Y_rd    = strb_q.y_rd;
  assign Z_rd    = strb_q.z_rd;
  assign HI_rd   = strb_q.hi_rd;
  assign LO_rd   = strb_q.lo_rd;
  assign IncPC   = strb_q.inc_pc;
  assign Read    = strb_q.read;
  assign R_rd    = r_rd_q;
  assign R_wrt   = r_wrt_q;
  assign op_sel  = op_sel_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle trace model plus literal checks.
module tb_alu_op_sequencer;

  localparam int TO = 15;

  typedef struct packed {
    logic busy, done, err, pc_out, mdr_out, zlo_out, zhi_out, mar_rd, pc_rd;
    logic mdr_rd, ir_rd, y_rd, z_rd, hi_rd, lo_rd, inc_pc, read;
    logic [15:0] r_rd;
    logic [15:0] r_wrt;
    logic [4:0]  op_sel;
  } snap_t;

  logic        clk, clr, start, mem_rdy;
  logic [31:0] ir;
  logic        busy, done, err, pc_out, mdr_out, zlo_out, zhi_out, mar_rd, pc_rd;
  logic        mdr_rd, ir_rd, y_rd, z_rd, hi_rd, lo_rd, inc_pc, read;
  logic [15:0] r_rd, r_wrt;
  logic [4:0]  op_sel;

  alu_op_sequencer #(
    .DATA_W(32), .NREGS(16), .REG_IDX_W(4), .OPC_W(5), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_rdy(mem_rdy),
    .busy(busy), .done(done), .err(err),
    .PC_out(pc_out), .MDR_out(mdr_out), .Zlo_out(zlo_out), .Zhi_out(zhi_out),
    .MAR_rd(mar_rd), .PC_rd(pc_rd), .MDR_rd(mdr_rd), .IR_rd(ir_rd),
    .Y_rd(y_rd), .Z_rd(z_rd), .HI_rd(hi_rd), .LO_rd(lo_rd),
    .IncPC(inc_pc), .Read(read),
    .R_rd(r_rd), .R_wrt(r_wrt), .op_sel(op_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  snap_t exp_q[$];
  int    checks, errors, cyc, start_cyc;
  logic  chk_on;
  int    done_cnt, err_cnt, read_cnt, y_cnt, lo_cnt, hi_cnt, rd_cnt, wrt_cnt;
  int    done_cyc, err_cyc;
  int    b_done, b_err, b_read, b_y, b_lo, b_hi, b_rd, b_wrt;
  int    cap_t3_wrt, cap_t4_wrt, cap_t4_op, cap_t5_rd;

  function automatic snap_t cur_snap();
    return {busy, done, err, pc_out, mdr_out, zlo_out, zhi_out, mar_rd, pc_rd,
            mdr_rd, ir_rd, y_rd, z_rd, hi_rd, lo_rd, inc_pc, read, r_rd, r_wrt, op_sel};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input int ra, input int rb, input int rc);
    return {opc, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic chk_snap(input string name, input snap_t act, input snap_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Expected per-cycle output trace of one instruction, from the instruction's meaning.
  task automatic push_trace(input logic [31:0] iv, input int nlow);
    snap_t       s;
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    logic        legal, unary, md, tmo;
    int          nt1;
    opc   = iv[31:27];
    ra    = iv[26:23];
    rb    = iv[22:19];
    rc    = iv[18:15];
    legal = opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000, 5'b10001, 5'b10010};
    unary = opc inside {5'b10001, 5'b10010};
    md    = opc inside {5'b01111, 5'b10000};
    tmo   = (nlow < 0) || (nlow > TO);
    nt1   = tmo ? TO + 1 : nlow + 1;
    s = '0; s.busy = 1; s.pc_out = 1; s.mar_rd = 1; s.inc_pc = 1; s.z_rd = 1;
    exp_q.push_back(s);
    for (int i = 0; i < nt1; i++) begin
      s = '0; s.busy = 1; s.zlo_out = 1; s.pc_rd = 1; s.read = 1; s.mdr_rd = 1;
      exp_q.push_back(s);
    end
    if (tmo) begin
      s = '0; s.busy = 1; s.err = 1; exp_q.push_back(s);
      return;
    end
    s = '0; s.busy = 1; s.mdr_out = 1; s.ir_rd = 1;
    exp_q.push_back(s);
    if (!legal) begin
      s = '0; s.busy = 1; s.err = 1; exp_q.push_back(s);
      return;
    end
    if (!unary) begin
      s = '0; s.busy = 1; s.y_rd = 1; s.r_wrt = 16'd1 << rb;
      exp_q.push_back(s);
    end
    s = '0; s.busy = 1; s.z_rd = 1; s.op_sel = opc;
    s.r_wrt = unary ? (16'd1 << rb) : (16'd1 << rc);
    exp_q.push_back(s);
    s = '0; s.busy = 1; s.zlo_out = 1;
    if (md) s.lo_rd = 1; else s.r_rd = 16'd1 << ra;
    exp_q.push_back(s);
    if (md) begin
      s = '0; s.busy = 1; s.zhi_out = 1; s.hi_rd = 1; exp_q.push_back(s);
    end
    s = '0; s.busy = 1; s.done = 1; exp_q.push_back(s);
  endtask

  // Per-cycle comparison against the trace model, plus event counters for literal checks.
  task automatic compare_loop();
    snap_t act, e;
    forever begin
      @(posedge clk);
      #1;
      act = cur_snap();
      cyc++;
      if (chk_on) begin
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk_snap($sformatf("trace_cycle_%0d", cyc), act, e);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (read) read_cnt++;
      if (y_rd) begin y_cnt++; cap_t3_wrt = int'(r_wrt); end
      if (z_rd && !inc_pc) begin cap_t4_wrt = int'(r_wrt); cap_t4_op = int'(op_sel); end
      if (zlo_out && !read) cap_t5_rd = int'(r_rd);
      if (lo_rd && zlo_out) lo_cnt++;
      if (hi_rd && zhi_out) hi_cnt++;
      if (r_rd != 16'd0) rd_cnt++;
      if (r_wrt != 16'd0) wrt_cnt++;
    end
  endtask

  // Issue one instruction; nlow = T1 cycles with mem_rdy low (negative: never ready);
  // pre = cycles start is held before the DUT can accept it.
  task automatic run_instr(input logic [31:0] iv, input int nlow, input int pre);
    b_done = done_cnt; b_err = err_cnt; b_read = read_cnt; b_y = y_cnt;
    b_lo = lo_cnt; b_hi = hi_cnt; b_rd = rd_cnt; b_wrt = wrt_cnt;
    cap_t3_wrt = -1; cap_t4_wrt = -1; cap_t4_op = -1; cap_t5_rd = -1;
    done_cyc = -1000; err_cyc = -1000;
    for (int i = 0; i < pre; i++) exp_q.push_back('0);
    push_trace(iv, nlow);
    start_cyc = cyc + pre;
    ir      = iv;
    mem_rdy = 1'b0;
    start   = 1'b1;
    repeat (pre) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    if (nlow >= 0) begin
      repeat (nlow + 1) @(negedge clk);
      mem_rdy = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; start = 1'b0; mem_rdy = 1'b0; ir = '0; chk_on = 1'b0;
    checks = 0; errors = 0; cyc = 0; start_cyc = 0;
    done_cnt = 0; err_cnt = 0; read_cnt = 0; y_cnt = 0; lo_cnt = 0; hi_cnt = 0;
    rd_cnt = 0; wrt_cnt = 0; done_cyc = 0; err_cyc = 0;
    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    chk_snap("reset_state", cur_snap(), '0);
    clr = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // Binary AND, Ra=4 Rb=5 Rc=7.
    chk("and_ir_encoding", int'(mk_ir(5'b00101, 4, 5, 7)), 32'h2A2B8000);
    run_instr(mk_ir(5'b00101, 4, 5, 7), 0, 0);
    drain();
    chk("and_t3_r_wrt", cap_t3_wrt, 32'h0020);
    chk("and_t4_r_wrt", cap_t4_wrt, 32'h0080);
    chk("and_t4_op_sel", cap_t4_op, 5);
    chk("and_t5_r_rd", cap_t5_rd, 32'h0010);
    chk("and_latency", done_cyc - start_cyc, 7);
    chk("and_done_pulses", done_cnt - b_done, 1);
    repeat (2) @(negedge clk);

    // Unary NOT, Ra=5 Rb=0.
    run_instr(mk_ir(5'b10010, 5, 0, 9), 0, 0);
    drain();
    chk("not_no_y_rd", y_cnt - b_y, 0);
    chk("not_t4_r_wrt", cap_t4_wrt, 32'h0001);
    chk("not_t4_op_sel", cap_t4_op, 18);
    chk("not_t5_r_rd", cap_t5_rd, 32'h0020);
    chk("not_latency", done_cyc - start_cyc, 6);
    repeat (2) @(negedge clk);

    // MUL: HI/LO writeback, no Ra load.
    run_instr(mk_ir(5'b01111, 1, 2, 3), 0, 0);
    drain();
    chk("mul_lo_rd", lo_cnt - b_lo, 1);
    chk("mul_hi_rd", hi_cnt - b_hi, 1);
    chk("mul_no_r_rd", rd_cnt - b_rd, 0);
    chk("mul_latency", done_cyc - start_cyc, 8);
    repeat (2) @(negedge clk);

    // SUB with three cycles of memory wait.
    run_instr(mk_ir(5'b00100, 14, 13, 12), 3, 0);
    drain();
    chk("wait3_read_cycles", read_cnt - b_read, 4);
    chk("wait3_latency", done_cyc - start_cyc, 10);
    repeat (2) @(negedge clk);

    // Memory never ready: timeout.
    run_instr(mk_ir(5'b00011, 1, 1, 1), -1, 0);
    drain();
    chk("timeout_err", err_cnt - b_err, 1);
    chk("timeout_no_done", done_cnt - b_done, 0);
    chk("timeout_err_latency", err_cyc - start_cyc, 18);
    repeat (2) @(negedge clk);

    // Ready arrives exactly when the limit is reached: ready wins.
    run_instr(mk_ir(5'b00011, 2, 3, 4), TO, 0);
    drain();
    chk("limit_ready_done", done_cnt - b_done, 1);
    chk("limit_ready_no_err", err_cnt - b_err, 0);
    chk("limit_ready_latency", done_cyc - start_cyc, 22);
    repeat (2) @(negedge clk);

    // Ready one cycle too late: timeout.
    run_instr(mk_ir(5'b10000, 6, 7, 8), TO + 1, 0);
    drain();
    chk("limit_late_err", err_cnt - b_err, 1);
    chk("limit_late_err_latency", err_cyc - start_cyc, 18);
    repeat (2) @(negedge clk);

    // Illegal opcode.
    run_instr(mk_ir(5'b11111, 3, 4, 5), 0, 0);
    drain();
    chk("illegal_err", err_cnt - b_err, 1);
    chk("illegal_no_done", done_cnt - b_done, 0);
    chk("illegal_err_latency", err_cyc - start_cyc, 4);
    chk("illegal_no_r_wrt", wrt_cnt - b_wrt, 0);
    chk("illegal_no_r_rd", rd_cnt - b_rd, 0);
    repeat (2) @(negedge clk);

    // Reset asserted during T4 of a binary op.
    run_instr(mk_ir(5'b00110, 9, 10, 11), 0, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_in_t4", int'(z_rd && !inc_pc), 1);
    chk_on = 1'b0;
    exp_q.delete();
    clr = 1'b0;
    #1;
    chk_snap("async_reset_outputs", cur_snap(), '0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    chk_on = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_abort_no_done", done_cnt - b_done, 0);
    chk("reset_abort_no_err", err_cnt - b_err, 0);

    // start pulsed while busy is ignored.
    run_instr(mk_ir(5'b00011, 8, 9, 10), 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("busy_start_one_done", done_cnt - b_done, 1);

    // start raised in the DONE cycle is taken only in the following IDLE cycle.
    run_instr(mk_ir(5'b00110, 1, 2, 3), 0, 0);
    drain();
    run_instr(mk_ir(5'b10001, 12, 11, 0), 0, 1);
    drain();
    chk("b2b_neg_latency", done_cyc - start_cyc, 6);
    chk("b2b_neg_t4_r_wrt", cap_t4_wrt, 32'h0800);
    chk("b2b_neg_t5_r_rd", cap_t5_rd, 32'h1000);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
